// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial stream, pattern-load and detection-result signals of seq_detector_param
interface seq_detector_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               din_valid;
    logic               din;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [PAT_LEN-1:0] pattern;

    modport master (
        output din_valid, din, overlap, pat_load, pat_in, cnt_clr,
        input  match, match_count, pattern
    );

    modport slave (
        input  din_valid, din, overlap, pat_load, pat_in, cnt_clr,
        output match, match_count, pattern
    );
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: reloadable serial pattern detector with registered match pulse.
// Define SEQDET_COUNT_EN to build the saturating match counter (otherwise match_count is 0).
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input logic                clk,
    input logic                reset,
    seq_detector_param_if.slave bus
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_sh;
    logic [PAT_LEN-1:0] pat_reg;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_inc;
    logic               accept;
    logic               hit;
    logic               match_r;

    // load has priority over an offered bit
    assign accept   = bus.din_valid && !bus.pat_load;
    assign hist_sh  = {hist[PAT_LEN-2:0], bus.din};
    assign fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
    assign hit      = accept && (fill_inc == FULL) && (hist_sh == pat_reg);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            pat_reg <= PATTERN;
            match_r <= 1'b0;
        end else begin
            match_r <= hit;
            if (bus.pat_load) begin
                pat_reg <= bus.pat_in;
                hist    <= '0;
                fill    <= '0;
            end else if (accept) begin
                hist <= (hit && !bus.overlap) ? '0 : hist_sh;
                fill <= (hit && !bus.overlap) ? '0 : fill_inc;
            end
        end
    end

    assign bus.match   = match_r;
    assign bus.pattern = pat_reg;

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt;

    // clear wins over a same-cycle hit
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (bus.cnt_clr)
            cnt <= '0;
        else if (hit && !(&cnt))
            cnt <= cnt + 1'b1;
    end

    assign bus.match_count = cnt;
`else
    logic unused_clr;

    assign unused_clr      = bus.cnt_clr;
    assign bus.match_count = '0;
`endif
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector for the serial-input datapath. It detects a configurable PAT_LEN-bit pattern in a qualified serial bit stream, and the pattern can be reloaded at run time. Overlapping or non-overlapping detection is selectable per cycle. Each detection raises a registered one-cycle pulse, and detections are tallied in an optional saturating counter.

## Interface
Parameters:
- PAT_LEN, 4, pattern length in bits (2..32)
- PATTERN, 4'b1011, reset-time pattern; MSB is the first bit received
- CNT_W, 8, match counter width (1..32)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- din_valid  in  1  qualifies din; bit accepted at rising edge when high
- din  in  1  serial data bit
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- pat_load  in  1  load pat_in as the new pattern
- pat_in  in  PAT_LEN  new pattern, MSB first-received
- cnt_clr  in  1  synchronous clear of match_count
- match  out  1  one-cycle detection pulse
- match_count  out  CNT_W  saturating number of detections
- pattern  out  PAT_LEN  currently active pattern

## Operation
Internal state:
- hist[PAT_LEN-1:0]: history shift register; the newest bit enters at bit 0.
- fill: number of valid history bits, range 0..PAT_LEN, saturating at PAT_LEN.
- pat_reg: the active pattern.

Accepted bit (din_valid=1, pat_load=0):
- hist <= {hist[PAT_LEN-2:0], din}.
- fill increments, saturating at PAT_LEN.

Hit condition:
- Evaluated on the post-shift value: new fill == PAT_LEN and new hist == pat_reg.
- On a hit, match <= 1 and match_count increments, saturating at all-ones.

Overlap mode, sampled on the hit cycle:
- overlap=1: fill stays PAT_LEN, so an overlapping occurrence can hit on the next bit that completes it.
- overlap=0: fill <= 0 and hist <= 0, so the next detection needs PAT_LEN fresh bits.

Other cycles:
- No accepted bit: hist and fill hold; match <= 0.
- pat_load=1: pat_reg <= pat_in, hist <= 0, fill <= 0, match <= 0. Any din offered in the same cycle is dropped, because load has priority.
- cnt_clr=1: match_count <= 0. If a hit occurs in the same cycle, the clear wins and match_count = 0, but match still pulses.

Reset values (asynchronous reset):
- match = 0
- match_count = 0
- pattern = PATTERN
- hist = 0
- fill = 0

## Timing
- Latency: match is high for exactly the one cycle after the rising edge that accepts the completing bit. This output is registered, with no combinational path from din.
- match_count updates on the same edge that sets match.
- Back-to-back hits in overlap mode give consecutive match pulses when the pattern permits, for example an all-ones pattern.
- din_valid gaps stall detection without losing history.
- Reset asserted mid-pattern discards partial history immediately. After release, detection requires PAT_LEN new bits.
- pattern reflects pat_reg and changes on the edge after pat_load.

## Configuration
- SEQDET_COUNT_EN defined: the match counter and cnt_clr logic are compiled in, as described above.
- SEQDET_COUNT_EN undefined:
  - No counter register.
  - match_count is tied to 0.
  - cnt_clr is ignored.
  - match behaviour is unchanged.

## Test plan
- Default pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 with din_valid=1 each cycle -> match pulses after bits 4 and 7; match_count=2.
- Same stream with overlap=0 -> match pulses only after bit 4; match_count=1.
- Stream 1,0,1,1 with din_valid low for 3 cycles between each bit -> exactly one match, one cycle after bit 4 is accepted; no spurious pulses during gaps.
- pat_load with pat_in=0110 while din_valid=1 and din=1:
  - Required: that din is dropped and pattern=0110.
  - Then stream 0,1,1,0 -> one match.
  - Then stream 1,0,1,1 -> no match.
- CNT_W=2, pattern 11, overlap=1, six consecutive 1s -> 5 match pulses; match_count saturates at 3. Then cnt_clr coinciding with a hit -> match=1, match_count=0.
- Send 1,0,1, assert reset for one cycle, then send 1 -> no match, all outputs at reset values. Then send 1,0,1,1 -> one match.
